// File: rtl/uart_tx_if.sv
// Host-side handshake and status bundle for the UART transmitter.
interface uart_tx_if;
  logic       trans_ena;
  logic [7:0] tx_data;
  logic       ovf_clr;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ovf;

  modport master (
    output trans_ena, tx_data, ovf_clr,
    input  tx, tx_busy, tx_done, tx_ovf
  );

  modport slave (
    input  trans_ena, tx_data, ovf_clr,
    output tx, tx_busy, tx_done, tx_ovf
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register and sticky overflow flag.
// All outputs are registered; tx drops low the cycle after an accepted request.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                bit_end_c;
  logic                last_stop_c;
  logic                ovf_set_c;

  assign bit_end_c   = (cnt_q == CNT_LAST);
  assign last_stop_c = (state_q == STOP) && bit_end_c;

  // Next-state, line level and holding-register control
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    ovf_set_c  = 1'b0;

    // Requests during a frame go to the holding register; the last STOP cycle is handled below
    if (bus.trans_ena && (state_q != IDLE) && !last_stop_c) begin
      if (hold_vld_q) begin
        ovf_set_c = 1'b1;
      end else begin
        hold_d     = bus.tx_data;
        hold_vld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (bus.trans_ena) begin
          shift_d = bus.tx_data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          done_d = 1'b1;
          if (hold_vld_q) begin
            shift_d = hold_q;
            state_d = START;
            tx_d    = 1'b0;
            if (bus.trans_ena) begin
              hold_d = bus.tx_data;
            end else begin
              hold_vld_d = 1'b0;
            end
          end else if (bus.trans_ena) begin
            shift_d = bus.tx_data;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
    ovf_d  = ovf_set_c | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign bus.tx_ovf  = ovf_q;
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port reset  input  1  reset is synchronous and active-high.
REQ-004 Port trans_ena  input  1  one-cycle transmit request pulse from the memory-mapped TX trigger.
REQ-005 Port tx_data  input  8  byte to send, sampled in the same cycle trans_ena is high.
REQ-006 Port ovf_clr  input  1  clears the sticky overflow flag.
REQ-007 Port tx  output  1  serial line, idle high.
REQ-008 Port tx_busy  output  1  high while a frame is in progress.
REQ-009 Port tx_done  output  1  one-cycle pulse per completed frame.
REQ-010 Port tx_ovf  output  1  sticky flag: a request was dropped.

Function
REQ-011 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; tx_busy = (state != IDLE), registered, glitch-free.
REQ-013 A 16-bit baud counter SHALL count 0..CLKS_PER_BIT-1 per bit and reset to 0 on every bit boundary; a 3-bit index SHALL select the DATA bit 0..7.
REQ-014 IDLE + trans_ena: tx_data SHALL be latched into the shift register and the FSM SHALL enter START; tx goes low on the first cycle after the request (latency 1 cycle).
REQ-015 START->DATA, DATA(bit 7)->STOP SHALL occur when the baud counter reaches CLKS_PER_BIT-1.
REQ-016 The block SHALL contain a one-byte holding register with valid flag.
REQ-017 trans_ena while busy with holding register empty SHALL load tx_data into the holding register; frame in progress is unaffected.
REQ-018 trans_ena while busy with holding register full (other than REQ-020 case) SHALL drop the byte and set tx_ovf; holding contents unchanged.
REQ-019 At the last STOP cycle: if holding valid, its byte SHALL move to the shift register, valid clears, FSM enters START (back-to-back, tx_busy stays high); otherwise FSM enters IDLE.
REQ-020 trans_ena in the last STOP cycle: with holding empty, tx_data SHALL go straight to the shift register and START; with holding full, holding byte starts and tx_data enters the holding register; no overflow in either case.
REQ-021 tx_done SHALL be high for exactly the one cycle following each last STOP cycle, including back-to-back frames.
REQ-022 tx_ovf SHALL stay high until ovf_clr; simultaneous set and ovf_clr SHALL leave tx_ovf high.
REQ-023 tx_data SHALL be ignored in cycles where trans_ena is low; changes on tx_data mid-frame SHALL not affect the line.

Reset
REQ-024 Reset SHALL force: tx=1, tx_busy=0, tx_done=0, tx_ovf=0, state IDLE, counters 0, holding valid 0.
REQ-025 Reset mid-frame SHALL abort the frame, discard the held byte, and return tx high on the next cycle; no tx_done is generated.
REQ-026 trans_ena asserted together with reset SHALL be ignored.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: trans_ena with 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_busy high 40 cycles; tx_done pulse on cycle 41.
REQ-028 Back-to-back: 0x55 then 0x0F 10 cycles later -> two contiguous 40-cycle frames, tx_busy high 80 cycles, two tx_done pulses 40 cycles apart, tx_ovf=0.
REQ-029 Overflow: three requests (0x11, 0x22, 0x33) within first frame -> 0x11 and 0x22 sent, 0x33 dropped, tx_ovf=1 until ovf_clr; ovf_clr with concurrent drop keeps tx_ovf=1.
REQ-030 Boundary: request 0x81 exactly on the last STOP cycle with holding empty -> next frame starts next cycle, no idle gap, tx_ovf=0.
REQ-031 Reset at cycle 15 of a frame with held byte -> tx=1, tx_busy=0 next cycle, no tx_done, held byte never sent.
REQ-032 Idle stimulus: tx_data toggling, trans_ena low for 100 cycles -> tx=1, tx_busy=0 throughout.
